// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared encodings for the multi-tap keypad decoder.
//   mode_e  : input mode encoding (ALPHABET / MORSE / SETTING)
//   state_e : decoder FSM state encoding
//   CODE_*  : control character codes produced by the key map
package keypad_pkg;

    typedef enum logic [1:0] {
        MODE_ALPHA   = 2'd0,
        MODE_MORSE   = 2'd1,
        MODE_SETTING = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPOSE = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    localparam logic [7:0] CODE_NONE  = 8'h00;
    localparam logic [7:0] CODE_BKSP  = 8'h08;
    localparam logic [7:0] CODE_ENTER = 8'h0D;
    localparam logic [7:0] CODE_SPACE = 8'h20;
    localparam logic [7:0] CODE_UP    = 8'h80;
    localparam logic [7:0] CODE_DOWN  = 8'h81;
    localparam logic [7:0] CODE_LEFT  = 8'h82;
    localparam logic [7:0] CODE_RIGHT = 8'h83;

endpackage

// File: rtl/multitap_key_decoder_key_map.sv
// key_map -- combinational keypad lookup (mode, tap state, key index -> code).
//   mode     : keypad_pkg::mode_e encoding
//   state    : tap index; 0 is the key's digit, 1..4 walk its letter group
//   key_idx  : key index 1..12 (anything else maps to 0x00)
//   key_data : character / control code
// Layout: keys 1..8 are letter keys, 9..12 are SPACE, BKSP, '0', ENTER.
module key_map
    import keypad_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [2:0] state,
    input  logic [3:0] key_idx,
    output logic [7:0] key_data
);

    // Four letters per letter key, first tap in the top byte.
    logic [31:0] letters;

    always_comb begin
        letters = 32'h0;
        case (key_idx)
            4'd1:    letters = ".,?!";
            4'd2:    letters = "UV-'";
            4'd3:    letters = "ABCD";
            4'd4:    letters = "WXYZ";
            4'd5:    letters = "EFGH";
            4'd6:    letters = "IJKL";
            4'd7:    letters = "MNOP";
            4'd8:    letters = "QRST";
            default: letters = 32'h0;
        endcase
    end

    always_comb begin
        key_data = CODE_NONE;
        case (mode)
            MODE_ALPHA: begin
                case (key_idx)
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                        case (state)
                            3'd0:    key_data = 8'h30 + {4'd0, key_idx};
                            3'd1:    key_data = letters[31:24];
                            3'd2:    key_data = letters[23:16];
                            3'd3:    key_data = letters[15:8];
                            3'd4:    key_data = letters[7:0];
                            default: key_data = CODE_NONE;
                        endcase
                    end
                    4'd9:    key_data = CODE_SPACE;
                    4'd10:   key_data = CODE_BKSP;
                    4'd11:   key_data = "0";
                    4'd12:   key_data = CODE_ENTER;
                    default: key_data = CODE_NONE;
                endcase
            end
            MODE_MORSE: begin
                case (key_idx)
                    4'd1:    key_data = "-";
                    4'd2:    key_data = ".";
                    4'd9:    key_data = CODE_SPACE;
                    4'd12:   key_data = CODE_ENTER;
                    default: key_data = CODE_NONE;
                endcase
            end
            MODE_SETTING: begin
                case (key_idx)
                    4'd1:    key_data = CODE_UP;
                    4'd2:    key_data = CODE_DOWN;
                    4'd3:    key_data = CODE_LEFT;
                    4'd4:    key_data = CODE_RIGHT;
                    4'd12:   key_data = CODE_ENTER;
                    default: key_data = CODE_NONE;
                endcase
            end
            default: key_data = CODE_NONE;
        endcase
    end

endmodule

// File: rtl/multitap_key_decoder.sv
// multitap_key_decoder -- phone-style multi-tap keypad to character stream.
//   clk, rst          : clock, asynchronous active-high reset
//   mode              : 0 ALPHABET, 1 MORSE, 2 SETTING; sampled on accepted press
//   key_valid/key_idx : key press strobe and index; key_ready gates acceptance
//   out_valid/out_data/out_ready : committed character, valid/ready handshake
//   preview_valid/preview_data   : character the composition would commit now
//   tap_state         : current tap index of the composition
//   drop_flag         : sticky, set when a press arrives while key_ready=0
// Letter keys in ALPHABET mode compose by repeated tapping; the character is
// committed by a different key or by TIMEOUT_CYC idle cycles. Control keys and
// the other modes emit immediately. A control key that interrupts a
// composition is parked in a one-entry pending slot (FLUSH) behind it.
module multitap_key_decoder
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS    = 12,
    parameter int CTRL_BASE   = 9,
    parameter int MAX_TAPS    = 5,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       key_valid,
    input  logic [3:0] key_idx,
    output logic       key_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       preview_valid,
    output logic [7:0] preview_data,
    output logic [2:0] tap_state,
    output logic       drop_flag
);

    localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]     TAP_LAST = 3'(MAX_TAPS - 1);

    state_e        state;
    mode_e         mode_lat;
    logic [3:0]    cur_key;
    logic [2:0]    tap;
    logic [TW-1:0] timer;
    logic          pend_valid;
    logic [7:0]    pend_data;

    mode_e      mode_in;
    mode_e      imm_mode;
    logic       key_in_range;
    logic       key_is_letter;
    logic       accept;
    logic [2:0] tap_next;
    logic [7:0] comp_code;
    logic [7:0] imm_code;

    assign mode_in = mode_e'(mode);

    // Mid-composition the latched mode decides how a key is classified and
    // looked up, so a mode switch cannot change the word being typed.
    assign imm_mode      = (state == ST_COMPOSE) ? mode_lat : mode_in;
    assign key_in_range  = (key_idx != 4'd0) && (int'(key_idx) <= NUM_KEYS);
    assign key_is_letter = (int'(key_idx) < CTRL_BASE) && (imm_mode == MODE_ALPHA);

    assign key_ready = ~out_valid & ~pend_valid;
    assign accept    = key_valid & key_ready & key_in_range;
    assign tap_next  = (tap == TAP_LAST) ? 3'd0 : tap + 3'd1;

    // Composition lookup feeds both preview and commits; the second instance
    // resolves immediate keys at tap 0.
    key_map u_km_comp (
        .mode     (mode_lat),
        .state    (tap),
        .key_idx  (cur_key),
        .key_data (comp_code)
    );

    key_map u_km_imm (
        .mode     (imm_mode),
        .state    (3'd0),
        .key_idx  (key_idx),
        .key_data (imm_code)
    );

    assign preview_valid = (state == ST_COMPOSE);
    assign preview_data  = (state == ST_COMPOSE) ? comp_code : 8'h00;
    assign tap_state     = tap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_lat   <= MODE_ALPHA;
            cur_key    <= 4'd0;
            tap        <= 3'd0;
            timer      <= '0;
            pend_valid <= 1'b0;
            pend_data  <= 8'h00;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            drop_flag  <= 1'b0;
        end else begin
            if (key_valid && !key_ready)
                drop_flag <= 1'b1;

            // Handshake retires the output; commits below override this when
            // they load a new character in the same cycle.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (key_is_letter) begin
                            state    <= ST_COMPOSE;
                            cur_key  <= key_idx;
                            tap      <= 3'd0;
                            timer    <= '0;
                            mode_lat <= mode_in;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= imm_code;
                        end
                    end
                end

                ST_COMPOSE: begin
                    // accept implies the output register is free here.
                    if (accept) begin
                        timer <= '0;
                        if (key_is_letter && key_idx == cur_key) begin
                            tap <= tap_next;
                        end else if (key_is_letter) begin
                            out_valid <= 1'b1;
                            out_data  <= comp_code;
                            cur_key   <= key_idx;
                            tap       <= 3'd0;
                        end else begin
                            out_valid  <= 1'b1;
                            out_data   <= comp_code;
                            pend_valid <= 1'b1;
                            pend_data  <= imm_code;
                            tap        <= 3'd0;
                            state      <= ST_FLUSH;
                        end
                    end else if (timer != T_LAST) begin
                        timer <= timer + 1'b1;
                    end else if (!out_valid) begin
                        // Timer parks at T_LAST until the previous character
                        // has been taken, then the timeout commit fires.
                        out_valid <= 1'b1;
                        out_data  <= comp_code;
                        tap       <= 3'd0;
                        timer     <= '0;
                        state     <= ST_IDLE;
                    end
                end

                ST_FLUSH: begin
                    if (out_valid && out_ready) begin
                        out_valid  <= 1'b1;
                        out_data   <= pend_data;
                        pend_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/multitap_key_decoder.md
MULTITAP_KEY_DECODER -- requirements
Module: multitap_key_decoder

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 12, number of valid key indices (1..NUM_KEYS).
REQ-002 SHALL have parameter CTRL_BASE, default 9, lowest key index treated as an immediate (non-multi-tap) key.
REQ-003 SHALL have parameter MAX_TAPS, default 5, number of tap states per letter key (state 0..MAX_TAPS-1).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50_000_000, idle cycles after the last tap before the character auto-commits.
REQ-005 SHALL have ports, one per line:
  clk  in  1  system clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  mode  in  2  0=ALPHABET, 1=MORSE, 2=SETTING; sampled on the accepted key press
  key_valid  in  1  one-cycle key press strobe
  key_idx  in  4  pressed key index
  key_ready  out  1  key press will be accepted this cycle
  out_valid  out  1  committed character available
  out_data  out  8  committed character code
  out_ready  in  1  consumer accepts out_data when out_valid & out_ready
  preview_valid  out  1  composition in progress
  preview_data  out  8  character the composition would commit now
  tap_state  out  3  current tap index
  drop_flag  out  1  sticky: a key press arrived while key_ready=0

Function
REQ-006 SHALL use a 3-state FSM: IDLE, COMPOSE, FLUSH.
REQ-007 SHALL accept a key press only when key_valid & key_ready, with key_ready = ~out_valid & ~pend_valid.
REQ-008 SHALL ignore key_idx==0 or key_idx>NUM_KEYS without state change.
REQ-009 SHALL, in ALPHABET mode with key_idx<CTRL_BASE from IDLE, enter COMPOSE with cur_key=key_idx, tap=0, timer=0, and latched mode.
REQ-010 SHALL, in COMPOSE, advance tap=(tap+1) mod MAX_TAPS when the same key is pressed again, and clear the timer.
REQ-011 SHALL, in COMPOSE, commit lookup(latched mode, tap, cur_key) when a different letter key is pressed, then restart COMPOSE on the new key with tap=0.
REQ-012 SHALL, in COMPOSE, commit the composed character when timer reaches TIMEOUT_CYC-1, then return to IDLE.
REQ-013 SHALL, on a key with key_idx>=CTRL_BASE or in MORSE/SETTING mode, emit lookup(mode, 0, key_idx) immediately from IDLE.
REQ-014 SHALL, on such a key arriving in COMPOSE, first commit the composed character and hold the immediate code in a one-entry pending slot (state FLUSH), then emit it after the first output is accepted.
REQ-015 SHALL register out_valid/out_data one cycle after the commit event and hold both stable until out_valid & out_ready.
REQ-016 SHALL saturate the timer while out_valid=1 and defer the timeout commit until the output register is free.
REQ-017 SHALL drive preview_valid=1 and preview_data=lookup(latched mode, tap, cur_key) combinationally in COMPOSE, and drive both to 0 elsewhere.
REQ-018 SHALL ignore mode changes during COMPOSE (latched mode governs).
REQ-019 SHALL set drop_flag on key_valid & ~key_ready, cleared only by reset.
REQ-020 SHALL size the timer to $clog2(TIMEOUT_CYC+1) bits.

Reset
REQ-021 SHALL, on rst=1 (asynchronous), force FSM=IDLE, tap_state=0, timer=0, pend_valid=0, out_valid=0, out_data=0x00, preview_valid=0, preview_data=0x00, drop_flag=0; key_ready=1 after release.
REQ-022 SHALL discard any in-progress composition or pending code on reset with no output emitted.

Structure
REQ-023 SHALL place the mode encodings (ALPHABET/MORSE/SETTING), FSM state encoding, and control codes (SPACE 0x20, ENTER 0x0D, UP 0x80) in a shared package (keypad_pkg).
REQ-024 SHALL instantiate the existing combinational KeyMap (mode, state, key_idx -> key_data) as its only sub-module for all lookups.

Verification (TIMEOUT_CYC=16, MAX_TAPS=5)
REQ-025 SHALL cover: ALPHABET, key 3 pressed twice 4 cycles apart, idle 16 cycles -> exactly one output "A"; preview "3" then "A".
REQ-026 SHALL cover: ALPHABET, key 4 pressed 5 times then timeout -> "Z"; 6 presses then timeout -> "4" (wrap).
REQ-027 SHALL cover: ALPHABET, key 1 then key 12 next cycle, out_ready=1 -> outputs "1" then 0x0D in order, no loss.
REQ-028 SHALL cover: MORSE, keys 1 then 2 -> "-" then "." each one cycle after the press, no timeout wait; SETTING key 1 -> 0x80.
REQ-029 SHALL cover: out_ready=0 with out_valid=1, press key 2 -> key_ready=0, drop_flag=1, out_data unchanged; raise out_ready -> one transfer.
REQ-030 SHALL cover: rst asserted mid-COMPOSE (key 5, tap 2) -> no output, preview_valid=0, tap_state=0 immediately.
